// File: rtl/cache_ctrl_pkg.sv
// Shared types and bus widths for the direct-mapped write-back cache controller.
package cache_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH  = 6;
    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned INDEX_WIDTH = 3;
    localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH;
    localparam int unsigned NUM_LINES   = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WB_WAIT   = 2'd1,
        FILL_WAIT = 2'd2
    } state_e;

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[INDEX_WIDTH-1:0];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:INDEX_WIDTH];
    endfunction

endpackage

// File: rtl/cache_ctrl_array.sv
// Tag/data/valid/dirty storage: combinational read by index, one synchronous write port.
module cache_ctrl_array
    import cache_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] i_rd_idx,
    output logic                   o_rd_valid,
    output logic                   o_rd_dirty,
    output logic [TAG_WIDTH-1:0]   o_rd_tag,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    input  logic                   i_wr_en,
    input  logic [INDEX_WIDTH-1:0] i_wr_idx,
    input  logic                   i_wr_valid,
    input  logic                   i_wr_dirty,
    input  logic [TAG_WIDTH-1:0]   i_wr_tag,
    input  logic [DATA_WIDTH-1:0]  i_wr_data
);

    logic [NUM_LINES-1:0]  r_valid;
    logic [NUM_LINES-1:0]  r_dirty;
    logic [TAG_WIDTH-1:0]  r_tag  [NUM_LINES];
    logic [DATA_WIDTH-1:0] r_data [NUM_LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

    // Only the status bits need clearing; tag/data are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_valid;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller with one-byte lines,
// one outstanding request, and write-back/fill transactions to main memory.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  op_e                   req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  mem_rst,
    output op_e                   mem_req_op,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_rsp_vld,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

    state_e                r_state;
    op_e                   r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    logic                   w_line_valid;
    logic                   w_line_dirty;
    logic [TAG_WIDTH-1:0]   w_line_tag;
    logic [DATA_WIDTH-1:0]  w_line_data;
    logic [INDEX_WIDTH-1:0] w_idx;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic                   w_hit;
    logic                   w_req;

    logic                   w_wr_en;
    logic [INDEX_WIDTH-1:0] w_wr_idx;
    logic                   w_wr_dirty;
    logic [TAG_WIDTH-1:0]   w_wr_tag;
    logic [DATA_WIDTH-1:0]  w_wr_data;

    assign mem_rst = rst;

    assign w_idx = addr_index(req_addr);
    assign w_tag = addr_tag(req_addr);
    assign w_hit = w_line_valid && (w_line_tag == w_tag);
    assign w_req = (r_state == IDLE) && (req_op != NOP);

    cache_ctrl_array u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_dirty (w_line_dirty),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_valid (1'b1),
        .i_wr_dirty (w_wr_dirty),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (w_wr_data)
    );

    // Array write: a write hit updates in place, a completed fill installs the line.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_idx   = w_idx;
        w_wr_dirty = 1'b0;
        w_wr_tag   = w_tag;
        w_wr_data  = req_data;
        if (w_req && w_hit && (req_op == WRITE)) begin
            w_wr_en    = 1'b1;
            w_wr_dirty = 1'b1;
        end else if ((r_state == FILL_WAIT) && mem_rsp_vld) begin
            w_wr_en    = 1'b1;
            w_wr_idx   = addr_index(r_addr);
            w_wr_tag   = addr_tag(r_addr);
            w_wr_dirty = (r_op == WRITE);
            w_wr_data  = (r_op == WRITE) ? r_data : mem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op         <= NOP;
            r_addr       <= '0;
            r_data       <= '0;
            rsp_vld      <= 1'b0;
            rsp_data     <= '0;
            mem_req_op   <= NOP;
            mem_req_addr <= '0;
            mem_req_data <= '0;
        end else begin
            rsp_vld    <= 1'b0;
            mem_req_op <= NOP;
            case (r_state)
                IDLE: begin
                    if (req_op != NOP) begin
                        r_op   <= req_op;
                        r_addr <= req_addr;
                        r_data <= req_data;
                        if (w_hit) begin
                            rsp_vld <= 1'b1;
                            if (req_op == READ) begin
                                rsp_data <= w_line_data;
                            end
                        end else if (w_line_valid && w_line_dirty) begin
                            r_state      <= WB_WAIT;
                            mem_req_op   <= WRITE;
                            mem_req_addr <= {w_line_tag, w_idx};
                            mem_req_data <= w_line_data;
                        end else begin
                            r_state      <= FILL_WAIT;
                            mem_req_op   <= READ;
                            mem_req_addr <= req_addr;
                        end
                    end
                end
                WB_WAIT: begin
                    if (mem_rsp_vld) begin
                        r_state      <= FILL_WAIT;
                        mem_req_op   <= READ;
                        mem_req_addr <= r_addr;
                    end
                end
                FILL_WAIT: begin
                    if (mem_rsp_vld) begin
                        r_state <= IDLE;
                        rsp_vld <= 1'b1;
                        if (r_op == READ) begin
                            rsp_data <= mem_rsp_data;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Only one request may be outstanding; anything arriving mid-miss is dropped.
    a_req_only_in_idle: assert property (@(posedge clk) disable iff (rst)
        (req_op != NOP) |-> (r_state == IDLE))
        else $error("cache_ctrl: request while busy is ignored");

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with a behavioural main memory of configurable latency.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    typedef struct {
        op_e        op;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    op_e        req_op;
    logic [5:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_vld;
    logic [7:0] rsp_data;
    logic       mem_rst;
    op_e        mem_req_op;
    logic [5:0] mem_req_addr;
    logic [7:0] mem_req_data;
    logic       mem_rsp_vld;
    logic [7:0] mem_rsp_data;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rsp_vld      (rsp_vld),
        .rsp_data     (rsp_data),
        .mem_rst      (mem_rst),
        .mem_req_op   (mem_req_op),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_data (mem_rsp_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // System-level view of memory (what a read must return) and the physical memory.
    logic [7:0] golden [64];
    logic [7:0] mem_arr [64];
    exp_t       sb_q [$];
    int         rsp_cnt = 0;

    // Memory model bookkeeping
    int         mem_lat = 3;
    bit         spur = 1'b0;
    bit         pend = 1'b0;
    int         cnt = 0;
    op_e        p_op = NOP;
    logic [5:0] p_addr = '0;
    logic [7:0] p_data = '0;
    int         mem_rd_cnt = 0;
    int         mem_wr_cnt = 0;
    int         mem_seq = 0;
    int         rd_seq = 0;
    int         wr_seq = 0;
    logic [5:0] last_rd_addr = '0;
    logic [5:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;

    always @(negedge clk) begin
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = 8'h00;
        if (mem_rst) begin
            pend = 1'b0;
        end else begin
            if (mem_req_op != NOP) begin
                mem_seq++;
                if (mem_req_op == READ) begin
                    mem_rd_cnt++;
                    rd_seq       = mem_seq;
                    last_rd_addr = mem_req_addr;
                end else begin
                    mem_wr_cnt++;
                    wr_seq       = mem_seq;
                    last_wr_addr = mem_req_addr;
                    last_wr_data = mem_req_data;
                end
                pend   = 1'b1;
                cnt    = mem_lat;
                p_op   = mem_req_op;
                p_addr = mem_req_addr;
                p_data = mem_req_data;
            end
            if (pend) begin
                if (cnt == 0) begin
                    if (p_op == WRITE) begin
                        mem_arr[p_addr] = p_data;
                    end else begin
                        mem_rsp_data = mem_arr[p_addr];
                    end
                    mem_rsp_vld = 1'b1;
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (spur) begin
                mem_rsp_vld  = 1'b1;
                mem_rsp_data = 8'hEE;
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp_vld pulse.
    always @(negedge clk) begin
        if (!rst && rsp_vld) begin
            exp_t e;
            rsp_cnt++;
            check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (e.op == READ) begin
                    check($sformatf("rsp_data@%02h", e.addr), 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    task automatic push_exp(input op_e op, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        if (op == WRITE) golden[a] = d;
        e.op   = op;
        e.addr = a;
        e.data = golden[a];
        sb_q.push_back(e);
    endtask

    task automatic do_req(input string tag, input op_e op, input logic [5:0] a,
                          input logic [7:0] d, input int exp_lat);
        int base;
        int lat;
        bit seen;
        @(negedge clk);
        req_op   = op;
        req_addr = a;
        req_data = d;
        push_exp(op, a, d);
        base = rsp_cnt;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) req_op = NOP;
            if (rsp_cnt != base) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
        end
        check({tag, "_resp_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int rd0;
        int wr0;
        int base;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 8'(i) ^ 8'hA0;
            golden[i]  = 8'(i) ^ 8'hA0;
        end
        rst      = 1'b1;
        req_op   = NOP;
        req_addr = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_mem_req_op", 32'(mem_req_op), 32'(NOP));
        check("rst_mem_req_addr", 32'(mem_req_addr), 32'd0);
        check("rst_mem_req_data", 32'(mem_req_data), 32'd0);
        check("rst_mem_rst", 32'(mem_rst), 32'd1);
        #1 rst = 1'b0;
        #1 check("mem_rst_release", 32'(mem_rst), 32'd0);

        // Clean read miss, memory latency 3
        rd0 = mem_rd_cnt; wr0 = mem_wr_cnt;
        do_req("rd05_miss", READ, 6'h05, 8'h00, 5);
        check("rd05_mem_reads", 32'(mem_rd_cnt - rd0), 32'd1);
        check("rd05_mem_writes", 32'(mem_wr_cnt - wr0), 32'd0);
        check("rd05_mem_addr", 32'(last_rd_addr), 32'h05);

        // Read hit
        rd0 = mem_rd_cnt;
        do_req("rd05_hit", READ, 6'h05, 8'h00, 1);
        check("rd05_hit_no_mem", 32'(mem_rd_cnt - rd0), 32'd0);

        // Write hit, then conflicting read forces a write-back before the fill
        rd0 = mem_rd_cnt; wr0 = mem_wr_cnt;
        do_req("wr05_hit", WRITE, 6'h05, 8'h3C, 1);
        check("wr05_hit_no_mem", 32'(mem_rd_cnt + mem_wr_cnt - rd0 - wr0), 32'd0);
        do_req("rd0d_dirty", READ, 6'h0D, 8'h00, 9);
        check("rd0d_wb_count", 32'(mem_wr_cnt - wr0), 32'd1);
        check("rd0d_wb_addr", 32'(last_wr_addr), 32'h05);
        check("rd0d_wb_data", 32'(last_wr_data), 32'h3C);
        check("rd0d_fill_addr", 32'(last_rd_addr), 32'h0D);
        check("rd0d_wb_before_fill", 32'(wr_seq < rd_seq), 32'd1);

        // Write-allocate on miss, then hit and dirty eviction
        rd0 = mem_rd_cnt; wr0 = mem_wr_cnt;
        do_req("wr12_miss", WRITE, 6'h12, 8'h77, 5);
        check("wr12_fill_count", 32'(mem_rd_cnt - rd0), 32'd1);
        check("wr12_fill_addr", 32'(last_rd_addr), 32'h12);
        check("wr12_no_wb", 32'(mem_wr_cnt - wr0), 32'd0);
        do_req("rd12_hit", READ, 6'h12, 8'h00, 1);
        do_req("rd1a_evict", READ, 6'h1A, 8'h00, 9);
        check("rd1a_wb_addr", 32'(last_wr_addr), 32'h12);
        check("rd1a_wb_data", 32'(last_wr_data), 32'h77);

        // Memory answers in the very next cycle
        mem_lat = 0;
        do_req("rd27_fast", READ, 6'h27, 8'h00, 2);
        mem_lat = 3;

        // Back-to-back hits: second request lands in the first one's response cycle
        rd0 = mem_rd_cnt; wr0 = mem_wr_cnt;
        base = rsp_cnt;
        @(negedge clk);
        req_op = READ; req_addr = 6'h0D; push_exp(READ, 6'h0D, 8'h00);
        @(negedge clk);
        req_op = READ; req_addr = 6'h1A; push_exp(READ, 6'h1A, 8'h00);
        @(negedge clk);
        #1 req_op = NOP;
        repeat (3) @(negedge clk);
        check("b2b_rsp_count", 32'(rsp_cnt - base), 32'd2);
        check("b2b_no_mem", 32'(mem_rd_cnt + mem_wr_cnt - rd0 - wr0), 32'd0);

        // Stray memory response while idle is ignored
        base = rsp_cnt;
        @(negedge clk);
        #1 spur = 1'b1;
        @(negedge clk);
        #1 spur = 1'b0;
        repeat (4) @(negedge clk);
        check("spur_no_rsp", 32'(rsp_cnt - base), 32'd0);
        check("spur_no_mem_req", 32'(mem_rd_cnt + mem_wr_cnt - rd0 - wr0), 32'd0);
        do_req("rd1a_after_spur", READ, 6'h1A, 8'h00, 1);

        // Reset while waiting for a fill abandons the miss
        mem_lat = 5;
        base = rsp_cnt;
        @(negedge clk);
        req_op = READ; req_addr = 6'h33;
        @(negedge clk);
        #1 req_op = NOP;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("mid_miss_mem_rst", 32'(mem_rst), 32'd1);
        @(negedge clk);
        check("post_rst_mem_req_op", 32'(mem_req_op), 32'(NOP));
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_miss_no_rsp", 32'(rsp_cnt - base), 32'd0);
        check("post_rst_rsp_vld", 32'(rsp_vld), 32'd0);
        for (int i = 0; i < 64; i++) golden[i] = mem_arr[i];
        mem_lat = 3;
        rd0 = mem_rd_cnt;
        do_req("rd05_after_rst", READ, 6'h05, 8'h00, 5);
        do_req("rd33_after_rst", READ, 6'h33, 8'h00, 5);
        check("after_rst_fills", 32'(mem_rd_cnt - rd0), 32'd2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache with one-byte lines.
- Sits between the requester-side memory bus and the main-memory bus. It consumes requester read/write requests and returns responses. On a miss it issues write-back and fill transactions downstream.
- Handles one outstanding request at a time.

Parameters:
ADDR_WIDTH, 6, byte address width; matches the bus req_addr.
DATA_WIDTH, 8, data width; matches the bus req_data/rsp_data.
INDEX_WIDTH, 3, index bits; number of lines = 2**INDEX_WIDTH; tag width = ADDR_WIDTH-INDEX_WIDTH.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  synchronous, active-high reset.
req_op  input  pkg::Op  requester op: NOP/READ/WRITE; non-NOP is a single-cycle request.
req_addr  input  ADDR_WIDTH  request address.
req_data  input  DATA_WIDTH  write data.
rsp_vld  output  1  one-cycle response pulse (READ data or WRITE ack).
rsp_data  output  DATA_WIDTH  read data; valid with rsp_vld.
mem_rst  output  1  memory reset; combinational copy of rst.
mem_req_op  output  pkg::Op  downstream op; non-NOP is a single-cycle request.
mem_req_addr  output  ADDR_WIDTH  downstream address.
mem_req_data  output  DATA_WIDTH  write-back data.
mem_rsp_vld  input  1  memory response pulse (read data or write ack).
mem_rsp_data  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset (rst sampled high):
  - all valid and dirty bits cleared;
  - state IDLE;
  - rsp_vld=0, rsp_data=0;
  - mem_req_op=NOP, mem_req_addr=0, mem_req_data=0.
  - Reset mid-miss abandons the transaction with no response; memory is reset in the same cycle via mem_rst.
- All outputs except mem_rst are registered. rsp_vld and mem_req_op default to 0/NOP every cycle unless set below.
- Lookup: index = addr[INDEX_WIDTH-1:0], tag = addr[ADDR_WIDTH-1:INDEX_WIDTH]. Hit = valid && stored tag == tag.
- States:
  - IDLE: on req_op!=NOP, latch op/addr/data.
    - Hit READ: rsp_vld=1, rsp_data=line data.
    - Hit WRITE: write line, set dirty, rsp_vld=1. Latency is 1 cycle: response in the cycle after the request.
    - Miss, victim valid && dirty: -> WB_WAIT; issue mem_req_op=WRITE, mem_req_addr={victim tag,index}, mem_req_data=victim data.
    - Miss otherwise: -> FILL_WAIT; issue mem_req_op=READ, mem_req_addr=latched addr.
  - WB_WAIT: on mem_rsp_vld -> FILL_WAIT; issue mem_req_op=READ for the latched addr.
  - FILL_WAIT: on mem_rsp_vld:
    - install tag, set valid;
    - latched READ: data=mem_rsp_data, dirty=0, rsp_vld=1, rsp_data=mem_rsp_data;
    - latched WRITE: data=latched data, dirty=1, rsp_vld=1;
    - then -> IDLE.
- Minimum miss latency: clean miss 2 cycles + memory latency; dirty miss adds a full write round trip.
- Boundary conditions:
  - Requests arriving outside IDLE are ignored; this is a protocol violation, flagged by a simulation assertion.
  - mem_rsp_vld outside a WAIT state is ignored.
  - A memory response in the cycle right after the request is accepted.
  - READ hit returns rsp_data from the pre-write array state. No same-cycle hazard exists because only one request is outstanding.
  - A request in the response cycle is accepted as new, since state is IDLE.
- Clean victims are overwritten silently.

Decomposition:
- pkg holds:
  - typedef enum logic [1:0] Op {NOP, READ, WRITE};
  - typedef enum State {IDLE, WB_WAIT, FILL_WAIT};
  - ADDR_WIDTH/DATA_WIDTH constants shared with the bus.
- One natural sub-module, cache_array: tag/data/valid/dirty storage.
  - Combinational read by index.
  - Synchronous write port with valid/dirty/tag/data.
  - Synchronous clear-all on rst.
- Controller FSM stays in cache_ctrl.
- Connects to the bus rx modport upstream and the tx modport downstream.

Test Plan:
- Reset, then READ 0x05, memory returns 0xA5 after 3 cycles -> mem_req_op=READ addr 0x05 once; rsp_vld one cycle with rsp_data=0xA5; no mem WRITE.
- Repeat READ 0x05 -> rsp_vld exactly 1 cycle after request, rsp_data=0xA5, mem_req_op stays NOP.
- WRITE 0x05=0x3C (hit), then READ 0x0D (same index, new tag) -> WRITE addr 0x05 data 0x3C issued first, then READ 0x0D after the ack; rsp_data = memory value.
- Miss WRITE 0x12=0x77 (clean) -> one mem READ 0x12, rsp_vld after fill; later READ 0x12 hits returning 0x77; eviction by 0x1A writes back 0x77 to 0x12.
- rst asserted in FILL_WAIT -> no rsp_vld; mem_rst high same cycle; next READ of that address misses.
- req_op=READ 0x20 held while in WB_WAIT -> ignored, assertion fires; only the original request gets rsp_vld.
